alu_shift_sequencer: RTL
========================

Name: alu_shift_sequencer

Overview:
- Multi-cycle sequencer for counted shift/rotate instructions (SHL/SHR/SHRA/ROL/ROR/ROLC/RORC by CL or imm8).
- Iterates the shared ALU's single-bit ops (SHL1, SHR1, SHRA1, ROL1, ROR1, ROLC1, RORC1) once per clock, `count` times.
- Feeds back the registered result and flags each step, so per-step flag behaviour and cycle cost match hardware for counts up to 255.
- Sits between the microcode execute stage and the `alu` instance; owns the ALU operand/op mux while busy.

Parameters:
- CNT_W, 8: width of the shift count; the count is never masked.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start_valid  in  1  request a counted shift
- start_ready  out  1  sequencer can accept a request
- start_op  in  3  0=ROL 1=ROR 2=ROLC 3=RORC 4=SHL 5=SHR 6=SHRA; 7 is reserved
- start_wide  in  1  1 = 16-bit, 0 = 8-bit
- start_operand  in  16  value to shift; bits [15:8] are ignored when narrow
- start_count  in  CNT_W  iteration count
- start_flags  in  flags_t  flags at request time
- abort  in  1  synchronous cancel (exception or flush)
- alu_op  out  alu_operation_e  single-bit op driven to the ALU
- alu_ta  out  16  ALU operand A
- alu_wide  out  1  ALU width
- alu_flags_in  out  flags_t  ALU flag input
- alu_result  in  16  ALU result
- alu_flags  in  flags_t  ALU flag output
- busy  out  1  sequencer owns the ALU
- done  out  1  one-cycle completion pulse
- result  out  16  final value, zero-extended when narrow
- flags_out  out  flags_t  final flags

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE; start_ready=1; busy=0; done=0.
  - result=0; flags_out=0; internal value/flags/counter=0.
  - alu_op=ALU_OP_SHL1; alu_ta=0; alu_wide=0; alu_flags_in=0.
- Accept occurs on a rising edge with start_valid & start_ready. It latches:
  - val = operand, masked to [7:0] when narrow;
  - flg = start_flags; cnt = start_count; op; wide.
- States:
  - IDLE: start_ready=1. On accept, go to ITER if count≠0, else DONE.
  - ITER:
    - busy=1; start_ready=0.
    - Combinationally drive alu_op = the mapped 1-bit op, alu_ta=val, alu_wide=wide, alu_flags_in=flg.
    - At the clock edge: val←alu_result, flg←alu_flags, cnt←cnt−1.
    - Leave to DONE when cnt==1 at that edge.
  - DONE:
    - done=1 for exactly one cycle; result=val; flags_out=flg; busy=0; start_ready=0.
    - Next state is IDLE.
- result and flags_out are registered and hold their value until the next DONE.
- Latency: done is asserted N+1 cycles after the accept edge (N=count). For count=0, done comes 1 cycle after accept, with result=operand and flags_out=start_flags unchanged.
- Throughput: the next request is accepted at the earliest on the edge ending the cycle after done.
- Op mapping: ROL→ROL1, ROR→ROR1, ROLC→ROLC1, RORC→RORC1, SHL→SHL1, SHR→SHR1, SHRA→SHRA1.
  - op=7 is accepted and completes as count=0.
- Final V, CY, P, S and Z are whatever the last single-bit step produced. Intermediate flags never leak to flags_out.
- When not busy, the ALU outputs hold their last values. The parent muxes the ALU using busy.
- abort:
  - In ITER or DONE: next state IDLE; done is suppressed in the following cycle; result/flags_out are not updated.
  - abort takes priority over the done transition.
  - abort in IDLE with a simultaneous accept: abort wins and the request is not accepted.
- Reset mid-operation returns to IDLE immediately and asynchronously; no done pulse.
- Narrow mode: alu_result[15:8] is ignored (val[15:8] is held 0).
- start_* inputs are don't-care except during an accept cycle.

Test Plan:
- Wide ROL, 0x8001, count=1, CY=0 → done 2 cycles after accept; result=0x0003, CY=1, V=1.
- Narrow SHL, 0x81, count=2 → two ALU steps observed (alu_ta 0x81 then 0x02); result=0x0004, CY=0, Z=0, S=0, P=0; done at accept+3.
- Count=0 SHRA, operand 0x1234, flags 0x0F5 → done at accept+1; result=0x1234; flags_out=0x0F5; alu_op never changes.
- Wide RORC, 0x0001, CY=0, count=17 → result=0x0001, CY=0 (full 17-bit rotation); done at accept+18; busy high 17 cycles.
- Narrow SHRA, 0x80, count=9 → result=0x00FF, CY=1, S=1.
- Narrow SHRA, 0x80, count=255 → same result; done at accept+256; start_valid held high is not accepted until the edge after done.
- Control abort: abort in step 3 of a count=10 SHL → no done; start_ready=1 next cycle; a new count=1 ROR of 0x0002 gives 0x0001 with CY=0.
- Reset abort: reset_n pulsed low mid-ITER → all outputs at reset values immediately.

Source files
------------

// File: rtl/alu_shift_sequencer.sv
// Counted shift/rotate sequencer: iterates the shared ALU's single-bit
// shift/rotate ops once per clock, feeding back the registered value and
// flags, and reports the final value/flags with a one-cycle done pulse.

package alu_shift_sequencer_pkg;
  // Flag word seen by the ALU; only the low five bits are touched by shifts.
  typedef struct packed {
    logic [6:0] misc;
    logic       v;
    logic       s;
    logic       z;
    logic       p;
    logic       cy;
  } flags_t;

  typedef enum logic [2:0] {
    ALU_OP_SHL1  = 3'd0,
    ALU_OP_SHR1  = 3'd1,
    ALU_OP_SHRA1 = 3'd2,
    ALU_OP_ROL1  = 3'd3,
    ALU_OP_ROR1  = 3'd4,
    ALU_OP_ROLC1 = 3'd5,
    ALU_OP_RORC1 = 3'd6
  } alu_operation_e;
endpackage

module alu_shift_sequencer
  import alu_shift_sequencer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [2:0]       start_op,
  input  logic             start_wide,
  input  logic [15:0]      start_operand,
  input  logic [CNT_W-1:0] start_count,
  input  flags_t           start_flags,
  input  logic             abort,
  output alu_operation_e   alu_op,
  output logic [15:0]      alu_ta,
  output logic             alu_wide,
  output flags_t           alu_flags_in,
  input  logic [15:0]      alu_result,
  input  flags_t           alu_flags,
  output logic             busy,
  output logic             done,
  output logic [15:0]      result,
  output flags_t           flags_out
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_e;

  state_e           state;
  logic [15:0]      val;
  flags_t           flg;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic             wide_q;

  // Last values driven to the ALU, so its inputs stay put while idle.
  alu_operation_e   op_hold;
  logic [15:0]      ta_hold;
  logic             wide_hold;
  flags_t           flg_hold;

  alu_operation_e   op_map;
  logic             accept;
  logic             zero_len;
  logic [15:0]      start_val;
  logic [15:0]      step_val;

  // Abort beats a simultaneous request; reserved op 7 runs as count 0.
  assign accept    = start_valid & start_ready & ~abort;
  assign zero_len  = (start_count == '0) | (start_op == 3'd7);
  assign start_val = start_wide ? start_operand : {8'h00, start_operand[7:0]};
  assign step_val  = wide_q ? alu_result : {8'h00, alu_result[7:0]};

  // Map the instruction's shift kind onto the ALU's single-bit op.
  always_comb begin
    op_map = ALU_OP_SHL1;
    case (op_q)
      3'd0:    op_map = ALU_OP_ROL1;
      3'd1:    op_map = ALU_OP_ROR1;
      3'd2:    op_map = ALU_OP_ROLC1;
      3'd3:    op_map = ALU_OP_RORC1;
      3'd4:    op_map = ALU_OP_SHL1;
      3'd5:    op_map = ALU_OP_SHR1;
      3'd6:    op_map = ALU_OP_SHRA1;
      default: op_map = ALU_OP_SHL1;
    endcase
  end

  // Drive the live step while iterating, otherwise hold the last drive.
  always_comb begin
    alu_op       = op_hold;
    alu_ta       = ta_hold;
    alu_wide     = wide_hold;
    alu_flags_in = flg_hold;
    if (state == S_ITER) begin
      alu_op       = op_map;
      alu_ta       = val;
      alu_wide     = wide_q;
      alu_flags_in = flg;
    end
  end

  // Sequencer FSM with registered handshake/status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      flags_out   <= '0;
      val         <= '0;
      flg         <= '0;
      cnt         <= '0;
      op_q        <= '0;
      wide_q      <= 1'b0;
      op_hold     <= ALU_OP_SHL1;
      ta_hold     <= '0;
      wide_hold   <= 1'b0;
      flg_hold    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            val         <= start_val;
            flg         <= start_flags;
            cnt         <= start_count;
            op_q        <= start_op;
            wide_q      <= start_wide;
            start_ready <= 1'b0;
            if (zero_len) begin
              state     <= S_DONE;
              done      <= 1'b1;
              result    <= start_val;
              flags_out <= start_flags;
            end else begin
              state <= S_ITER;
              busy  <= 1'b1;
            end
          end
        end
        S_ITER: begin
          op_hold   <= op_map;
          ta_hold   <= val;
          wide_hold <= wide_q;
          flg_hold  <= flg;
          val       <= step_val;
          flg       <= alu_flags;
          cnt       <= cnt - CNT_W'(1);
          if (abort) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            start_ready <= 1'b1;
          end else if (cnt == CNT_W'(1)) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            result    <= step_val;
            flags_out <= alu_flags;
          end
        end
        S_DONE: begin
          state       <= S_IDLE;
          start_ready <= 1'b1;
        end
        default: begin
          state       <= S_IDLE;
          busy        <= 1'b0;
          start_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
